// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 8x8 LED matrix scan controller.
package led_matrix_pkg;

  localparam int unsigned NCOLS    = 8;
  localparam int unsigned NROWS    = 8;
  localparam int unsigned COL_W    = $clog2(NCOLS);
  localparam int unsigned BRIGHT_W = 4;
  localparam int unsigned NTICKS   = (1 << BRIGHT_W) - 1;
  localparam int unsigned FRAME_W  = NCOLS * NROWS;

  // Frame buffer: [col][row], bit 8c+r of the flat shift image.
  typedef logic [NCOLS-1:0][NROWS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin, with synced level and a
// single-cycle rising-edge pulse derived from a history flop.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level  = r_sync;
  assign o_rise_c = r_sync & ~r_prev;

endmodule

// File: rtl/led_scan_controller.sv
// LED matrix scan controller: serial frame loader with double buffering and a
// column scanner with blanking and per-column PWM brightness.
module led_scan_controller
  import led_matrix_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic                dclk,
  input  logic                strobe,
  input  logic                enable,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [NROWS-1:0]    row_out,
  output logic [NCOLS-1:0]    col_sel,
  output logic                frame_start,
  output logic                swap_pending
);

  localparam int unsigned CYC_MAX = (BLANK_CYCLES > PRESCALE) ? BLANK_CYCLES : PRESCALE;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CYC_W-1:0]    BLANK_LAST = CYC_W'(BLANK_CYCLES - 1);
  localparam logic [CYC_W-1:0]    PRE_LAST   = CYC_W'(PRESCALE - 1);
  localparam logic [BRIGHT_W-1:0] TICK_LAST  = BRIGHT_W'(NTICKS - 1);
  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(NCOLS - 1);

  logic w_din_sync;
  logic w_din_rise_unused;
  logic w_dclk_level_unused;
  logic w_dclk_rise;
  logic w_strobe_level_unused;
  logic w_strobe_rise;

  sync_edge_detect u_sync_din (
    .clk      (clk),
    .reset    (reset),
    .i_pin    (din),
    .o_level  (w_din_sync),
    .o_rise_c (w_din_rise_unused)
  );

  sync_edge_detect u_sync_dclk (
    .clk      (clk),
    .reset    (reset),
    .i_pin    (dclk),
    .o_level  (w_dclk_level_unused),
    .o_rise_c (w_dclk_rise)
  );

  sync_edge_detect u_sync_strobe (
    .clk      (clk),
    .reset    (reset),
    .i_pin    (strobe),
    .o_level  (w_strobe_level_unused),
    .o_rise_c (w_strobe_rise)
  );

  logic [FRAME_W-1:0] r_shift;
  frame_t             r_staging;
  frame_t             r_display;
  logic               r_pend;

  scan_state_e         r_state;
  logic [COL_W-1:0]    r_col;
  logic [CYC_W-1:0]    r_cyc;
  logic [BRIGHT_W-1:0] r_tick;
  logic [BRIGHT_W-1:0] r_bright_l;
  logic [NROWS-1:0]    r_row_out;
  logic [NCOLS-1:0]    r_col_sel;
  logic                r_frame_start;

  scan_state_e         w_state_nxt;
  logic [COL_W-1:0]    w_col_nxt;
  logic [CYC_W-1:0]    w_cyc_nxt;
  logic [BRIGHT_W-1:0] w_tick_nxt;
  logic [BRIGHT_W-1:0] w_bright_nxt;
  logic [NROWS-1:0]    w_row_out_nxt;
  logic [NCOLS-1:0]    w_col_sel_nxt;
  logic                w_frame_start_nxt;
  logic                w_swap;

  // Load path: shift, stage on strobe, swap into display at frame start.
  // A strobe in the swap cycle stages new data after the old staging is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_staging <= '0;
      r_display <= '0;
      r_pend    <= 1'b0;
    end else begin
      if (w_dclk_rise) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_din_sync};
      end
      if (w_swap) begin
        r_display <= r_staging;
      end
      if (w_strobe_rise) begin
        r_staging <= r_shift;
        r_pend    <= 1'b1;
      end else if (w_swap) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_cyc         <= '0;
      r_tick        <= '0;
      r_bright_l    <= '0;
      r_row_out     <= '0;
      r_col_sel     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_cyc         <= w_cyc_nxt;
      r_tick        <= w_tick_nxt;
      r_bright_l    <= w_bright_nxt;
      r_row_out     <= w_row_out_nxt;
      r_col_sel     <= w_col_sel_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // Scan sequencing; outputs are computed from the next state so they register
  // in the same cycle the state changes.
  always_comb begin
    w_state_nxt       = r_state;
    w_col_nxt         = r_col;
    w_cyc_nxt         = r_cyc;
    w_tick_nxt        = r_tick;
    w_bright_nxt      = r_bright_l;
    w_frame_start_nxt = 1'b0;
    w_swap            = 1'b0;
    w_row_out_nxt     = '0;
    w_col_sel_nxt     = '0;

    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt       = BLANK;
          w_col_nxt         = '0;
          w_cyc_nxt         = '0;
          w_tick_nxt        = '0;
          w_bright_nxt      = brightness;
          w_frame_start_nxt = 1'b1;
          w_swap            = r_pend;
        end
      end
      BLANK: begin
        if (r_cyc == BLANK_LAST) begin
          w_cyc_nxt   = '0;
          w_tick_nxt  = '0;
          w_state_nxt = (r_bright_l != '0) ? ON : OFF;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ON, OFF: begin
        // Ticks run 0..14 across ON then OFF; the last tick always ends the column.
        if (r_cyc == PRE_LAST) begin
          w_cyc_nxt = '0;
          if (r_tick == TICK_LAST) begin
            w_state_nxt = BLANK;
            w_tick_nxt  = '0;
            if (r_col == COL_LAST) begin
              w_col_nxt         = '0;
              w_bright_nxt      = brightness;
              w_frame_start_nxt = 1'b1;
              w_swap            = r_pend;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end else begin
            w_tick_nxt  = r_tick + BRIGHT_W'(1);
            w_state_nxt = (w_tick_nxt < r_bright_l) ? ON : OFF;
          end
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!enable) begin
      w_state_nxt       = IDLE;
      w_col_nxt         = '0;
      w_cyc_nxt         = '0;
      w_tick_nxt        = '0;
      w_frame_start_nxt = 1'b0;
      w_swap            = 1'b0;
    end

    if (w_state_nxt == ON) begin
      w_row_out_nxt = r_display[w_col_nxt];
      w_col_sel_nxt = NCOLS'(1) << w_col_nxt;
    end
  end

  assign row_out      = r_row_out;
  assign col_sel      = r_col_sel;
  assign frame_start  = r_frame_start;
  assign swap_pending = r_pend;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with a frame-time behavioural model
// checked every cycle, plus hand-computed spot checks.
module tb_led_scan_controller;

  localparam int PRESCALE  = 4;
  localparam int BLANK     = 2;
  localparam int COL_LEN   = BLANK + 15 * PRESCALE;
  localparam int FRAME_LEN = 8 * COL_LEN;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       dclk;
  logic       strobe;
  logic       enable;
  logic [3:0] brightness;
  logic [7:0] row_out;
  logic [7:0] col_sel;
  logic       frame_start;
  logic       swap_pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int on_cnt;
  int hit_cnt;

  led_scan_controller #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .dclk         (dclk),
    .strobe       (strobe),
    .enable       (enable),
    .brightness   (brightness),
    .row_out      (row_out),
    .col_sel      (col_sel),
    .frame_start  (frame_start),
    .swap_pending (swap_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pins sampled per edge, effects 2 samples later; scan position is
  // time since frame start.
  logic [63:0] m_shift, m_stage, m_disp;
  bit          m_pend, m_run;
  int          m_t, m_bright;
  logic [2:0]  h_din, h_dclk, h_stb;
  logic [7:0]  e_row, e_col;
  logic        e_fs, e_pend;

  always @(posedge clk or posedge reset) begin
    bit dclk_p, stb_p, start;
    int c, p;
    if (reset) begin
      m_shift = '0; m_stage = '0; m_disp = '0; m_pend = 0; m_run = 0;
      m_t = 0; m_bright = 0;
      h_din = '0; h_dclk = '0; h_stb = '0;
      e_row = '0; e_col = '0; e_fs = 1'b0; e_pend = 1'b0;
    end else begin
      dclk_p = h_dclk[1] & ~h_dclk[2];
      stb_p  = h_stb[1] & ~h_stb[2];
      start  = 0;
      if (!enable) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0; start = 1;
      end else begin
        m_t++;
        if (m_t == FRAME_LEN) begin
          m_t = 0; start = 1;
        end
      end
      if (start) begin
        m_bright = int'(brightness);
        if (m_pend) begin
          m_disp = m_stage;
          m_pend = 0;
        end
      end
      if (stb_p) begin
        m_stage = m_shift;
        m_pend  = 1;
      end
      if (dclk_p) m_shift = {m_shift[62:0], h_din[1]};
      h_din  = {h_din[1:0], din};
      h_dclk = {h_dclk[1:0], dclk};
      h_stb  = {h_stb[1:0], strobe};
      e_fs   = start;
      e_pend = m_pend;
      e_row  = '0;
      e_col  = '0;
      if (m_run) begin
        c = m_t / COL_LEN;
        p = m_t % COL_LEN;
        if (p >= BLANK && p < BLANK + m_bright * PRESCALE) begin
          e_col = 8'(1 << c);
          e_row = m_disp[8*c +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_row_out", row_out, e_row);
      check("model_col_sel", col_sel, e_col);
      check("model_frame_start", frame_start, e_fs);
      check("model_swap_pending", swap_pending, e_pend);
    end
  end

  task automatic send_bit(input logic b);
    din = b;
    repeat (3) @(negedge clk);
    dclk = 1'b1;
    repeat (3) @(negedge clk);
    dclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_frame(input logic [63:0] f);
    for (int i = 63; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_fs(input string nm);
    @(negedge clk);
    for (int i = 0; i < 1200 && !frame_start; i++) @(negedge clk);
    check(nm, frame_start, 1'b1);
  endtask

  task automatic wait_col(input logic [7:0] val, input string nm);
    @(negedge clk);
    for (int i = 0; i < 1200 && col_sel != val; i++) @(negedge clk);
    check(nm, col_sel, val);
  endtask

  // Called at the negedge showing frame_start; walks one full frame.
  task automatic frame_stats(input logic [7:0] sel, input logic [7:0] val,
                             output int on_n, output int hit_n);
    on_n  = 0;
    hit_n = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (col_sel != 8'h00) on_n++;
      if (col_sel == sel && row_out == val) hit_n++;
      @(negedge clk);
    end
    check("frame_period", frame_start, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; din = 1'b0; dclk = 1'b0; strobe = 1'b0;
    enable = 1'b0; brightness = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_row_out", row_out, 8'h00);
    check("rst_col_sel", col_sel, 8'h00);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_swap_pending", swap_pending, 1'b0);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Load and swap, full brightness
    brightness = 4'd15;
    load_frame(64'h0000_0000_0000_00A5);
    pulse_strobe();
    check("pend_after_strobe", swap_pending, 1'b1);
    enable = 1'b1;
    wait_fs("fs_first");
    check("pend_cleared_at_swap", swap_pending, 1'b0);
    check("blank_at_fs", col_sel, 8'h00);
    frame_stats(8'h01, 8'hA5, on_cnt, hit_cnt);
    check("on_cycles_b15", 64'(on_cnt), 64'd480);
    check("col0_a5_cycles_b15", 64'(hit_cnt), 64'd60);

    // PWM duty, brightness changed mid-frame
    repeat (100) @(negedge clk);
    brightness = 4'd4;
    wait_fs("fs_b4");
    frame_stats(8'h01, 8'hA5, on_cnt, hit_cnt);
    check("on_cycles_b4", 64'(on_cnt), 64'd128);
    check("col0_a5_cycles_b4", 64'(hit_cnt), 64'd16);
    repeat (100) @(negedge clk);
    brightness = 4'd0;
    wait_fs("fs_b0");
    frame_stats(8'h01, 8'hA5, on_cnt, hit_cnt);
    check("on_cycles_b0", 64'(on_cnt), 64'd0);
    check("col0_cycles_b0", 64'(hit_cnt), 64'd0);

    // Deferred swap
    brightness = 4'd15;
    load_frame(64'hFFFF_FFFF_FFFF_FFFF);
    pulse_strobe();
    wait_fs("fs_ff");
    check("pend_cleared_ff", swap_pending, 1'b0);
    load_frame(64'hF0E0_D0C0_B0A0_900F);
    wait_fs("fs_pre_deferred");
    repeat (100) @(negedge clk);
    pulse_strobe();
    check("pend_mid_frame", swap_pending, 1'b1);
    wait_col(8'h04, "col2_on_old");
    check("row_unchanged_mid_frame", row_out, 8'hFF);
    wait_fs("fs_deferred");
    check("pend_cleared_deferred", swap_pending, 1'b0);
    wait_col(8'h01, "col0_on_new");
    check("row_new_col0", row_out, 8'h0F);
    wait_col(8'h02, "col1_on_new");
    check("row_new_col1", row_out, 8'h90);

    // Two strobes before the boundary
    enable = 1'b0;
    @(negedge clk);
    load_frame(64'h1111_1111_1111_113C);
    pulse_strobe();
    load_frame(64'h2222_2222_2222_225A);
    pulse_strobe();
    check("pend_double", swap_pending, 1'b1);
    enable = 1'b1;
    wait_fs("fs_double");
    check("pend_cleared_double", swap_pending, 1'b0);
    wait_col(8'h01, "col0_on_double");
    check("row_second_frame", row_out, 8'h5A);

    // Strobe landing in the swap cycle
    enable = 1'b0;
    @(negedge clk);
    load_frame(64'h4444_4444_4444_4481);
    pulse_strobe();
    load_frame(64'h8888_8888_8888_887E);
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("fs_coincident", frame_start, 1'b1);
    check("pend_coincident", swap_pending, 1'b1);
    @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    wait_col(8'h01, "col0_on_coinc");
    check("row_old_staging", row_out, 8'h81);
    wait_fs("fs_after_coinc");
    check("pend_cleared_coinc", swap_pending, 1'b0);
    wait_col(8'h01, "col0_on_after_coinc");
    check("row_new_staging", row_out, 8'h7E);

    // Enable drop during col 5 ON
    wait_col(8'h20, "col5_on");
    enable = 1'b0;
    @(negedge clk);
    check("drop_col_sel", col_sel, 8'h00);
    check("drop_row_out", row_out, 8'h00);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_fs", frame_start, 1'b1);
    check("reenable_blank0", col_sel, 8'h00);
    @(negedge clk);
    check("reenable_blank1", col_sel, 8'h00);
    @(negedge clk);
    check("reenable_col0", col_sel, 8'h01);

    // Reset during col 3 ON
    wait_fs("fs_pre_reset");
    pulse_strobe();
    check("pend_before_reset", swap_pending, 1'b1);
    wait_col(8'h08, "col3_on");
    #2 reset = 1'b1;
    #1;
    check("async_rst_row_out", row_out, 8'h00);
    check("async_rst_col_sel", col_sel, 8'h00);
    check("async_rst_swap_pending", swap_pending, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_from_idle_fs", frame_start, 1'b1);
    check("restart_blank", col_sel, 8'h00);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
